// File: rtl/alu_io_pkg.sv
// Shared defaults and helpers for the ALU operand/opcode input controller.
package alu_io_pkg;

  localparam int DEF_N_SW      = 16;
  localparam int DEF_N_DATA    = 8;
  localparam int DEF_CHUNK     = 4;
  localparam int DEF_N_OP      = 6;
  localparam int DEF_DB_CYCLES = 1_000_000;

  // One-cycle press pulses from the four debounced buttons.
  typedef struct packed {
    logic exec;
    logic op;
    logic b;
    logic a;
  } press_t;

  // Width of a counter that must hold 0..nchunk inclusive.
  function automatic int cnt_width(input int nchunk);
    return (nchunk < 1) ? 1 : $clog2(nchunk + 1);
  endfunction

endpackage

// File: rtl/alu_chunk_loader_if.sv
// Switch/button inputs and ALU operand/opcode outputs of the chunk loader.
interface alu_chunk_loader_if
  import alu_io_pkg::*;
#(
  parameter int N_SW   = DEF_N_SW,
  parameter int N_DATA = DEF_N_DATA,
  parameter int N_OP   = DEF_N_OP
);

  logic [N_SW-1:0]   i_sw;
  logic              i_button_A;
  logic              i_button_B;
  logic              i_button_Op;
  logic              i_button_Exec;
  logic [N_DATA-1:0] o_alu_A;
  logic [N_DATA-1:0] o_alu_B;
  logic [N_OP-1:0]   o_alu_Op;
  logic              o_ready;
  logic              o_start;
  logic              o_error;

  // Board side: drives switches and buttons, observes the ALU ports.
  modport master (
    output i_sw, i_button_A, i_button_B, i_button_Op, i_button_Exec,
    input  o_alu_A, o_alu_B, o_alu_Op, o_ready, o_start, o_error
  );

  // Controller side.
  modport slave (
    input  i_sw, i_button_A, i_button_B, i_button_Op, i_button_Exec,
    output o_alu_A, o_alu_B, o_alu_Op, o_ready, o_start, o_error
  );

endinterface

// File: rtl/alu_chunk_loader_button_debouncer.sv
// Synchronises, debounces and edge-detects one raw push-button.
module button_debouncer #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level;
  logic          level_d;
  logic          press;

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value; the reset branch is synchronous and also clears the
  // synchroniser so nothing stale leaks out after reset release.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync    <= {sync[0], i_btn};
      level_d <= level;
      press   <= level & ~level_d;
      // Any sample agreeing with the current level restarts the stability window.
      if (sync[1] != level) begin
        if (cnt == LAST) begin
          level <= ~level;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign o_level = level;
  assign o_press = press;

endmodule

// File: rtl/alu_chunk_loader.sv
// Loads wide ALU operands chunk-by-chunk from switches and gates the execute strobe.
module alu_chunk_loader
  import alu_io_pkg::*;
#(
  parameter int N_SW      = DEF_N_SW,
  parameter int N_DATA    = DEF_N_DATA,
  parameter int CHUNK     = DEF_CHUNK,
  parameter int N_OP      = DEF_N_OP,
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input logic               i_clock,
  input logic               i_reset,
  alu_chunk_loader_if.slave bus
);

  localparam int NCHUNK = N_DATA / CHUNK;
  localparam int CW     = cnt_width(NCHUNK);
  localparam logic [CW-1:0] FULL = CW'(NCHUNK);

  generate
    if (N_SW < 2 * CHUNK + N_OP) begin : g_bad_nsw
      $error("alu_chunk_loader: N_SW too small for two chunks plus opcode");
    end
    if ((N_DATA % CHUNK) != 0) begin : g_bad_chunk
      $error("alu_chunk_loader: N_DATA must be a multiple of CHUNK");
    end
  endgenerate

  press_t press;
  press_t level;

  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_a (
    .i_clock(i_clock), .i_reset(i_reset), .i_btn(bus.i_button_A),
    .o_level(level.a), .o_press(press.a));
  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_b (
    .i_clock(i_clock), .i_reset(i_reset), .i_btn(bus.i_button_B),
    .o_level(level.b), .o_press(press.b));
  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_op (
    .i_clock(i_clock), .i_reset(i_reset), .i_btn(bus.i_button_Op),
    .o_level(level.op), .o_press(press.op));
  button_debouncer #(.DB_CYCLES(DB_CYCLES)) u_db_exec (
    .i_clock(i_clock), .i_reset(i_reset), .i_btn(bus.i_button_Exec),
    .o_level(level.exec), .o_press(press.exec));

  logic [CHUNK-1:0]  chunk_a;
  logic [CHUNK-1:0]  chunk_b;
  logic [N_OP-1:0]   op_field;
  logic [N_DATA-1:0] alu_a;
  logic [N_DATA-1:0] alu_b;
  logic [N_OP-1:0]   alu_op;
  logic [CW-1:0]     cnt_a;
  logic [CW-1:0]     cnt_b;
  logic              op_loaded;
  logic              ready;
  logic              start;
  logic              error;
  logic              any_load;

  assign chunk_a  = bus.i_sw[CHUNK-1:0];
  assign chunk_b  = bus.i_sw[2*CHUNK-1:CHUNK];
  assign op_field = bus.i_sw[N_SW-1:N_SW-N_OP];
  assign ready    = (cnt_a == FULL) && (cnt_b == FULL) && op_loaded;
  assign any_load = press.a | press.b | press.op;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      cnt_a     <= '0;
      cnt_b     <= '0;
      op_loaded <= 1'b0;
      start     <= 1'b0;
      error     <= 1'b0;
    end else begin
      // A full operand restarts entry with the new chunk in the LSBs.
      if (press.a) begin
        if (cnt_a == FULL) begin
          alu_a <= N_DATA'(chunk_a);
          cnt_a <= CW'(1);
        end else begin
          alu_a <= (alu_a << CHUNK) | N_DATA'(chunk_a);
          cnt_a <= cnt_a + CW'(1);
        end
      end
      if (press.b) begin
        if (cnt_b == FULL) begin
          alu_b <= N_DATA'(chunk_b);
          cnt_b <= CW'(1);
        end else begin
          alu_b <= (alu_b << CHUNK) | N_DATA'(chunk_b);
          cnt_b <= cnt_b + CW'(1);
        end
      end
      if (press.op) begin
        alu_op    <= op_field;
        op_loaded <= 1'b1;
      end
      // Exec judges the pre-load state; a concurrent load always rejects it.
      start <= press.exec & ready & ~any_load;
      error <= press.exec & ~(ready & ~any_load);
    end
  end

  assign bus.o_alu_A  = alu_a;
  assign bus.o_alu_B  = alu_b;
  assign bus.o_alu_Op = alu_op;
  assign bus.o_ready  = ready;
  assign bus.o_start  = start;
  assign bus.o_error  = error;

endmodule

// File: tb/tb_alu_chunk_loader.sv
// Directed bench for alu_chunk_loader with a short debounce window.
module tb_alu_chunk_loader;

  localparam int N_SW = 16;
  localparam int N_DATA = 8;
  localparam int CHUNK = 4;
  localparam int N_OP = 6;
  localparam int DB = 4;

  typedef struct {
    logic [3:0]  btn;        // {exec, op, b, a}
    logic [15:0] sw;
    logic [7:0]  exp_a;
    logic [7:0]  exp_b;
    logic [5:0]  exp_op;
    logic        exp_ready;
    int          exp_starts;
    int          exp_errors;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_start = 0;
  int   n_err = 0;
  vec_t vecs[14];

  always #5 clk = ~clk;

  alu_chunk_loader_if #(.N_SW(N_SW), .N_DATA(N_DATA), .N_OP(N_OP)) bus ();

  alu_chunk_loader #(
    .N_SW(N_SW), .N_DATA(N_DATA), .CHUNK(CHUNK), .N_OP(N_OP), .DB_CYCLES(DB)
  ) dut (
    .i_clock(clk),
    .i_reset(rst_n),
    .bus(bus)
  );

  function automatic logic [15:0] mk_sw(input logic [5:0] op, input logic [3:0] b,
                                        input logic [3:0] a);
    return {op, 2'b00, b, a};
  endfunction

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance one clock and sample just after the edge, tallying strobes.
  task automatic step();
    @(posedge clk);
    #1;
    if (bus.o_start === 1'b1) n_start++;
    if (bus.o_error === 1'b1) n_err++;
  endtask

  task automatic set_buttons(input logic [3:0] m);
    bus.i_button_A    = m[0];
    bus.i_button_B    = m[1];
    bus.i_button_Op   = m[2];
    bus.i_button_Exec = m[3];
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    set_buttons(4'b0000);
    repeat (cycles) step();
    rst_n = 1'b1;
  endtask

  // Clean press and release, each long enough for a full debounce.
  task automatic press(input logic [3:0] m, input logic [15:0] sw);
    bus.i_sw = sw;
    set_buttons(m);
    repeat (10) step();
    set_buttons(4'b0000);
    repeat (10) step();
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({bus.o_alu_A, bus.o_alu_B, bus.o_alu_Op,
                      bus.o_ready, bus.o_start, bus.o_error}), 32'd0);
  endtask

  initial begin
    int k;
    bus.i_sw = '0;
    set_buttons(4'b0000);

    vecs[0]  = '{4'b0001, mk_sw(6'h00, 4'h0, 4'hA), 8'h0A, 8'h00, 6'h00, 1'b0, 0, 0};
    vecs[1]  = '{4'b0001, mk_sw(6'h00, 4'h0, 4'h5), 8'hA5, 8'h00, 6'h00, 1'b0, 0, 0};
    vecs[2]  = '{4'b0001, mk_sw(6'h00, 4'h0, 4'h3), 8'h03, 8'h00, 6'h00, 1'b0, 0, 0};
    vecs[3]  = '{4'b0001, mk_sw(6'h00, 4'h0, 4'hA), 8'h3A, 8'h00, 6'h00, 1'b0, 0, 0};
    vecs[4]  = '{4'b0001, mk_sw(6'h00, 4'h0, 4'hA), 8'h0A, 8'h00, 6'h00, 1'b0, 0, 0};
    vecs[5]  = '{4'b0001, mk_sw(6'h00, 4'h0, 4'h5), 8'hA5, 8'h00, 6'h00, 1'b0, 0, 0};
    vecs[6]  = '{4'b0010, mk_sw(6'h00, 4'h3, 4'hF), 8'hA5, 8'h03, 6'h00, 1'b0, 0, 0};
    vecs[7]  = '{4'b0100, mk_sw(6'h15, 4'h9, 4'h9), 8'hA5, 8'h03, 6'h15, 1'b0, 0, 0};
    vecs[8]  = '{4'b1000, mk_sw(6'h3F, 4'h1, 4'h1), 8'hA5, 8'h03, 6'h15, 1'b0, 0, 1};
    vecs[9]  = '{4'b0010, mk_sw(6'h00, 4'hC, 4'h0), 8'hA5, 8'h3C, 6'h15, 1'b1, 0, 0};
    vecs[10] = '{4'b1000, mk_sw(6'h01, 4'h7, 4'h7), 8'hA5, 8'h3C, 6'h15, 1'b1, 1, 0};
    vecs[11] = '{4'b1100, mk_sw(6'h2A, 4'h6, 4'h6), 8'hA5, 8'h3C, 6'h2A, 1'b1, 0, 1};
    vecs[12] = '{4'b0011, mk_sw(6'h11, 4'h2, 4'h1), 8'h01, 8'h02, 6'h2A, 1'b0, 0, 0};
    vecs[13] = '{4'b1000, mk_sw(6'h00, 4'h0, 4'h0), 8'h01, 8'h02, 6'h2A, 1'b0, 0, 1};

    // Reset held three cycles clears every output; idle release yields nothing.
    do_reset(3);
    check_all_zero("reset_outputs");
    n_start = 0;
    n_err = 0;
    repeat (20) step();
    check_all_zero("idle_after_reset");
    check("idle_strobes", 32'(n_start + n_err), 32'd0);

    // Bounce shorter than the window, then a stable hold: one load, 8 edges later.
    bus.i_sw = mk_sw(6'h00, 4'h0, 4'h7);
    for (int i = 0; i < 10; i++) begin
      bus.i_button_A = ~i[0];
      repeat (2) step();
    end
    check("bounce_no_load", 32'(bus.o_alu_A), 32'h00);
    bus.i_button_A = 1'b1;
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (bus.o_alu_A !== 8'h00) begin
        k = i;
        break;
      end
    end
    check("bounce_latency", 32'(k), 32'd8);
    repeat (15) step();
    check("held_single_load", 32'(bus.o_alu_A), 32'h07);
    bus.i_button_A = 1'b0;
    repeat (10) step();

    do_reset(2);
    check_all_zero("reset_before_table");

    for (int i = 0; i < 14; i++) begin
      n_start = 0;
      n_err = 0;
      press(vecs[i].btn, vecs[i].sw);
      check($sformatf("v%0d_A", i), 32'(bus.o_alu_A), 32'(vecs[i].exp_a));
      check($sformatf("v%0d_B", i), 32'(bus.o_alu_B), 32'(vecs[i].exp_b));
      check($sformatf("v%0d_Op", i), 32'(bus.o_alu_Op), 32'(vecs[i].exp_op));
      check($sformatf("v%0d_ready", i), 32'(bus.o_ready), 32'(vecs[i].exp_ready));
      check($sformatf("v%0d_starts", i), 32'(n_start), 32'(vecs[i].exp_starts));
      check($sformatf("v%0d_errors", i), 32'(n_err), 32'(vecs[i].exp_errors));
    end

    // Reset inside the second A chunk's debounce window discards everything.
    bus.i_sw = mk_sw(6'h00, 4'h0, 4'h9);
    bus.i_button_A = 1'b1;
    repeat (4) step();
    check("mid_no_load_yet", 32'(bus.o_alu_A), 32'h01);
    do_reset(2);
    check_all_zero("mid_reset_clear");
    n_start = 0;
    n_err = 0;
    repeat (20) step();
    check_all_zero("mid_no_load_after");
    check("mid_strobes", 32'(n_start + n_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_chunk_loader.md
# alu_chunk_loader

Next-generation operand/opcode input controller for the board-level ALU test. It debounces and edge-detects four push-buttons and loads operands wider than the available switch field by shifting them in over several presses. It also loads the opcode and issues a single-cycle execute strobe to the ALU only when every operand is complete. It sits between the board switches/buttons and the ALU operand/opcode ports.

## Interface
- N_SW, 16: switch count; must satisfy N_SW ≥ 2·CHUNK + N_OP
- N_DATA, 8: ALU operand width; must be a multiple of CHUNK
- CHUNK, 4: switch bits loaded per press, per operand
- N_OP, 6: opcode width
- DB_CYCLES, 1_000_000: consecutive stable samples required to accept a button level; ≥ 1

- i_clock  in  1  system clock; all logic rising-edge
- i_reset  in  1  synchronous, active-low reset
- i_sw  in  N_SW  raw switches: A chunk = [CHUNK-1:0], B chunk = [2·CHUNK-1:CHUNK], opcode = [N_SW-1:N_SW-N_OP]
- i_button_A, i_button_B, i_button_Op, i_button_Exec  in  1 each  raw, asynchronous, bouncing buttons
- o_alu_A, o_alu_B  out  N_DATA  operand registers
- o_alu_Op  out  N_OP  opcode register
- o_ready  out  1  A complete, B complete and opcode loaded
- o_start  out  1  one-cycle execute strobe
- o_error  out  1  one-cycle strobe on a rejected execute

## Operation
- Each button: 2-FF synchroniser, then debounce counter. The debounced level toggles only after DB_CYCLES consecutive synchronised samples that differ from it. A rising edge of the debounced level gives a one-cycle press pulse.
- NCHUNK = N_DATA/CHUNK. cnt_A and cnt_B count 0..NCHUNK.
- A press:
  - If cnt_A < NCHUNK: o_alu_A ← {o_alu_A[N_DATA-CHUNK-1:0], i_sw[CHUNK-1:0]}, cnt_A++. The first chunk loaded ends in the MSBs.
  - If cnt_A == NCHUNK: o_alu_A ← zero-extended chunk, cnt_A ← 1. This restarts entry.
  - If NCHUNK == 1: direct load, cnt_A ← 1.
- B press: same as A, using the B chunk field.
- Op press: o_alu_Op ← opcode field; op_loaded ← 1.
- o_ready = (cnt_A == NCHUNK) && (cnt_B == NCHUNK) && op_loaded. Combinational from registers.
- Exec press:
  - If o_ready is 1 and no A/B/Op press occurs in the same cycle: o_start pulses.
  - Otherwise: o_error pulses.
  - Registers are never altered by Exec.
- Simultaneous A/B/Op presses are all applied in the same cycle.
- An Exec press together with any load press gives o_error, and the loads still apply.

## Timing
- Reset (i_reset == 0 at a clock edge) clears all registers, counters, debounce state and synchroniser flops. All outputs read 0, including o_ready/o_start/o_error.
- Reset mid-debounce or mid-entry discards progress; no pulse follows reset release.
- Button press to press pulse: 2 (sync) + DB_CYCLES + 1 (edge) cycles after the first stable sample.
- Press pulse to register update: 1 cycle. o_start/o_error are registered, asserting the cycle after the Exec pulse for exactly 1 cycle.
- A held button produces exactly one pulse. Release plus re-press requires a full debounce in each direction.
- Bounces shorter than DB_CYCLES never produce a pulse.

## Structure
- Package alu_io_pkg: default N_DATA/CHUNK/N_OP, and a width-check localparam function for clog2 of NCHUNK+1. Elaboration asserts on the N_SW and N_DATA%CHUNK constraints.
- Sub-module button_debouncer (parameter DB_CYCLES; ports i_clock, i_reset, i_btn, o_level, o_press), instantiated four times.
- Top level holds the chunk counters, shift registers, opcode register and exec arbitration.

## Test plan
Bench parameters: DB_CYCLES = 4.
- Reset: hold i_reset = 0 for 3 cycles → all outputs 0; release with buttons idle → no pulses.
- Bounce rejection: toggle i_button_A every 2 cycles for 20 cycles, then hold 1 → exactly one A load, 2+4+1+1 cycles after the stable hold begins.
- Chunked load: sw A-field 0xA, press A; then 0x5, press A → o_alu_A = 0xA5, cnt_A = 2. A third press with 0x3 → o_alu_A = 0x03, cnt_A = 1.
- Execute gating: A = 0xA5 complete, B 1 of 2 chunks, opcode loaded, press Exec → o_error pulse, no o_start. Complete B = 0x3C, press Exec → o_start for 1 cycle, o_ready = 1.
- Simultaneous: with o_ready = 1, Op and Exec debounced pulses on the same cycle → o_error pulse, o_alu_Op updated to the new switch value.
- Reset mid-operation: reset during the second A chunk's debounce window → o_alu_A = 0, no load after release.
